// File: rtl/bcd_seg_pkg.sv
// Shared widths, segment encodings and the segment word type for the BCD
// seven-segment scan driver and its digit decoder.
package bcd_seg_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  // Active-high segments, bit order gfedcba.
  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes
// (10-15) show a single dash on segment g.
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  seg_t code;

  // NOTE: every path through an always_comb assigns its outputs (here via the
  // case default); a missing assignment would infer a latch.
  always_comb begin
    code = SEG_DASH;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
  end

  assign seg = code;

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed seven-segment scan driver with frame-synchronous BCD word commit.
// Define BCD_SEG_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an
);

  localparam int DATA_W = BCD_W * NUM_DIGITS;
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     shadow;
  logic [DATA_W-1:0]     display;
  logic                  pending;
  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  terminal;
  logic                  frame_end;
  logic                  xfer;
  logic [BCD_W-1:0]      digit;
  logic [SEG_W-1:0]      digit_seg;
  logic                  blank;
  logic [SEG_W-1:0]      seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign terminal   = (cnt == CNT_LAST);
  assign frame_end  = terminal && (idx == IDX_LAST);
  assign load_ready = !pending;
  assign xfer       = load_valid && load_ready;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (terminal) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The display register only changes at a frame boundary, so a scan never
  // mixes digits from two different words. Commit and capture are exclusive
  // because capture requires pending to be clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (frame_end && pending) begin
      display <= shadow;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= bcd_in;
      pending <= 1'b1;
    end
  end

  assign digit = display[BCD_W*idx +: BCD_W];

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

`ifdef BCD_SEG_SCAN_LZB_EN
  logic [IDX_W-1:0] lead;

  // Index of the most significant nonzero digit; digit 0 is always kept.
  always_comb begin
    lead = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display[i*BCD_W +: BCD_W] != '0) lead = IDX_W'(i);
    end
  end

  assign blank = (idx > lead);
`else
  assign blank = 1'b0;
`endif

  // Slot 0 of every digit is dark so the anode switch never shows the
  // previous digit's segments.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '0;
    if ((cnt != '0) && !blank) begin
      seg_d = digit_seg;
      an_d  = NUM_DIGITS'(1) << idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4); also
// covers leading-zero blanking when BCD_SEG_SCAN_LZB_EN is defined.
module tb_bcd_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   bcd_in;
  logic [6:0]    seg;
  logic [3:0]    an;

  always #5 clk = ~clk;

  bcd_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .bcd_in     (bcd_in),
    .seg        (seg),
    .an         (an)
  );

  // word, expected segments {d3,d2,d1,d0}, digits lit under blanking
  typedef struct packed {
    logic [15:0]     word;
    logic [3:0][6:0] segs;
    logic [3:0]      lit;
  } vec_t;

  vec_t vecs [6];

  int passed;
  int total;
  int k;

  logic [3:0][6:0] m_disp, m_shad, drv_segs;
  logic [3:0]      m_lit, s_lit, drv_lit;
  logic            m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic reset_model();
    k      = 0;
    m_disp = {4{7'h3F}};
    m_lit  = 4'b0001;
    m_shad = '0;
    s_lit  = '0;
    m_pend = 1'b0;
  endtask

  task automatic drive(input int i, input logic v);
    bcd_in     = vecs[i].word;
    drv_segs   = vecs[i].segs;
    drv_lit    = vecs[i].lit;
    load_valid = v;
  endtask

  // One clock: predict the registered outputs from the pre-edge scan
  // position and display, then update the word-level model.
  task automatic step();
    int c, d;
    logic shown, fe, xfer;
    logic [3:0] ea;
    logic [6:0] es;
    c = k % RD;
    d = (k / RD) % ND;
    shown = (c != 0);
`ifdef BCD_SEG_SCAN_LZB_EN
    if (!m_lit[d]) shown = 1'b0;
`endif
    ea   = shown ? 4'(1 << d) : 4'h0;
    es   = shown ? m_disp[d] : 7'h00;
    fe   = (c == RD - 1) && (d == ND - 1);
    xfer = load_valid && !m_pend;
    @(posedge clk);
    #1;
    k++;
    if (fe && m_pend) begin
      m_disp = m_shad;
      m_lit  = s_lit;
      m_pend = 1'b0;
    end else if (xfer) begin
      m_shad = drv_segs;
      s_lit  = drv_lit;
      m_pend = 1'b1;
    end
    check($sformatf("an@%0d", k), an, ea);
    check($sformatf("seg@%0d", k), seg, es);
    check($sformatf("load_ready@%0d", k), load_ready, !m_pend);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (load_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("ready_wait_timeout", n < 64, 1);
  endtask

  task automatic step_until(input int phase);
    int n = 0;
    do begin
      step();
      n++;
    end while ((k % FRAME) != phase && n < 64);
    check("frame_wait_timeout", n < 64, 1);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    bcd_in     = '0;
    drv_segs   = '0;
    drv_lit    = '0;
    reset_model();

    vecs[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111};
    vecs[1] = '{16'h56C9, {7'h6D, 7'h7D, 7'h40, 7'h6F}, 4'b1111};
    vecs[2] = '{16'h0070, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0011};
    vecs[3] = '{16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0001};
    vecs[4] = '{16'h8F0A, {7'h7F, 7'h40, 7'h3F, 7'h40}, 4'b1111};
    vecs[5] = '{16'h0900, {7'h3F, 7'h6F, 7'h3F, 7'h3F}, 4'b0111};

    #2;
    check("reset_seg", seg, 7'h00);
    check("reset_an", an, 4'h0);
    check("reset_load_ready", load_ready, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();

    // Table: load mid-frame, wait for the commit, then watch one full frame.
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      drive(i, 1'b1);
      step();
      check($sformatf("ready_fall_v%0d", i), load_ready, 1'b0);
      drive(i, 1'b0);
      step_until(0);
      check($sformatf("ready_after_commit_v%0d", i), load_ready, 1'b1);
      repeat (FRAME) step();
    end

    // Second word held while pending: accepted only once ready returns.
    drive(0, 1'b1);
    step();
    drive(1, 1'b1);
    wait_ready();
    step();
    check("held_word_captured", load_ready, 1'b0);
    drive(1, 1'b0);
    step_until(0);
    repeat (FRAME) step();

    // Capture on the frame-end edge with nothing pending: commit is deferred.
    step_until(FRAME - 1);
    drive(4, 1'b1);
    step();
    check("frame_end_capture", load_ready, 1'b0);
    drive(4, 1'b0);
    repeat (FRAME) step();
    check("deferred_commit_ready", load_ready, 1'b1);
    repeat (FRAME) step();

    // Reset mid-frame with a word pending: everything clears, word is lost.
    drive(5, 1'b1);
    step();
    drive(5, 1'b0);
    repeat (5) step();
    check("pending_before_reset", load_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_seg", seg, 7'h00);
    check("midreset_an", an, 4'h0);
    check("midreset_load_ready", load_ready, 1'b1);
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME * 2 + 4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
